// File: rtl/glyph_ram_arbiter.sv
// Shares the single-port synchronous-read glyph RAM between the display fetch
// (always wins, fixed two-edge latency) and a req/ack host load/inspect port.
//
//   state     | meaning
//   H_IDLE    | no host access in flight; grant possible in a free RAM cycle
//   H_ISSUED  | host access sitting in the RAM port registers
//   H_DATA    | RAM has sampled the access; read data on ramRdData
//   H_ACK     | hostAck pulse; mandatory idle cycle follows
module glyph_ram_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BLANK_ONLY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispReadEn,
  input  logic [ADDR_W-1:0] dispAddr,
  input  logic              blank,
  output logic [DATA_W-1:0] dispByte,
  output logic              dispValid,
  input  logic              hostReq,
  input  logic              hostWe,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWrData,
  output logic              hostAck,
  output logic [DATA_W-1:0] hostRdData,
  output logic              hostBusy,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWrData,
  input  logic [DATA_W-1:0] ramRdData
);

  localparam logic [1:0] H_IDLE   = 2'd0;
  localparam logic [1:0] H_ISSUED = 2'd1;
  localparam logic [1:0] H_DATA   = 2'd2;
  localparam logic [1:0] H_ACK    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              host_rd_q, host_rd_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
  logic              disp_p1_q, disp_p2_q;
  logic [DATA_W-1:0] disp_byte_q, disp_byte_d;
  logic              disp_valid_q;
  logic [DATA_W-1:0] host_rd_data_q, host_rd_data_d;
  logic              blank_ok;
  logic              grant;

  assign blank_ok = (BLANK_ONLY == 0) || blank;
  assign grant    = (state_q == H_IDLE) && hostReq && !dispReadEn && blank_ok;

  // RAM port: display first, then a host grant, otherwise an idle cycle that
  // keeps the last address/data on the bus.
  always_comb begin
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    if (dispReadEn) begin
      ram_en_d   = 1'b1;
      ram_addr_d = dispAddr;
    end else if (grant) begin
      ram_en_d      = 1'b1;
      ram_we_d      = hostWe;
      ram_addr_d    = hostAddr;
      ram_wr_data_d = hostWrData;
    end
  end

  always_comb begin
    state_d        = state_q;
    host_rd_d      = host_rd_q;
    host_rd_data_d = host_rd_data_q;
    case (state_q)
      H_IDLE: begin
        if (grant) begin
          state_d   = H_ISSUED;
          host_rd_d = !hostWe;
        end
      end
      H_ISSUED: state_d = H_DATA;
      H_DATA: begin
        state_d = H_ACK;
        if (host_rd_q) host_rd_data_d = ramRdData;
      end
      default: state_d = H_IDLE;
    endcase
  end

  assign disp_byte_d = disp_p2_q ? ramRdData : disp_byte_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= H_IDLE;
      host_rd_q      <= 1'b0;
      host_rd_data_q <= '0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wr_data_q  <= '0;
      disp_p1_q      <= 1'b0;
      disp_p2_q      <= 1'b0;
      disp_byte_q    <= '0;
      disp_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      host_rd_q      <= host_rd_d;
      host_rd_data_q <= host_rd_data_d;
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wr_data_q  <= ram_wr_data_d;
      disp_p1_q      <= dispReadEn;
      disp_p2_q      <= disp_p1_q;
      disp_byte_q    <= disp_byte_d;
      disp_valid_q   <= disp_p2_q;
    end
  end

  assign dispByte   = disp_byte_q;
  assign dispValid  = disp_valid_q;
  assign hostAck    = (state_q == H_ACK);
  assign hostBusy   = (state_q != H_IDLE);
  assign hostRdData = host_rd_data_q;
  assign ramEn      = ram_en_q;
  assign ramWe      = ram_we_q;
  assign ramAddr    = ram_addr_q;
  assign ramWrData  = ram_wr_data_q;

endmodule
